// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, widths and the fetch FSM encoding.
package cpu_pkg;

    localparam int INS_W    = 18;
    localparam int PC_W     = 14;

    localparam int OPC_MSB  = 17;
    localparam int OPC_LSB  = 14;
    localparam int DST_MSB  = 13;
    localparam int DST_LSB  = 10;
    localparam int REG2_MSB = 9;
    localparam int REG2_LSB = 6;
    localparam int REG1_MSB = 5;
    localparam int REG1_LSB = 2;
    localparam int IMM_MSB  = 5;
    localparam int IMM_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input logic [INS_W-1:0] ins);
        return ins[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch program counter: reset value, redirect load, and modulo-2^PC_W increment.
module fetch_pc_reg #(
    parameter int              PC_W     = cpu_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [PC_W-1:0] load_pc,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    // A redirect always wins; increment wraps naturally at the register width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc <= RESET_PC;
        else if (load)
            pc <= load_pc;
        else if (inc)
            pc <= pc + 1'b1;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: requests words from instruction memory and hands them one at a
// time to the control unit, honouring branch/jump redirects at any point.
module instr_fetch_unit #(
    parameter int              PC_W     = cpu_pkg::PC_W,
    parameter int              INS_W    = cpu_pkg::INS_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [INS_W-1:0] ins,
    output logic             ins_valid,
    output logic [PC_W-1:0]  ins_pc,
    input  logic             ins_accept,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [INS_W-1:0] imem_rdata,
    output logic [15:0]      fetch_count
);
    import cpu_pkg::*;

    fetch_state_t    state, state_next;
    logic            flush;
    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] issue_addr;
    logic            pc_inc, issue, req_drop, deliver, invalidate, retire;
    logic            flush_set, flush_clr;

    // A redirect arriving in the same cycle as a new issue goes straight onto the bus.
    assign issue_addr = redirect ? redirect_pc : fetch_pc;

    fetch_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_fetch_pc (
        .clk     (clk),
        .rst     (rst),
        .load    (redirect),
        .load_pc (redirect_pc),
        .inc     (pc_inc),
        .pc      (fetch_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        pc_inc     = 1'b0;
        issue      = 1'b0;
        req_drop   = 1'b0;
        deliver    = 1'b0;
        invalidate = 1'b0;
        retire     = 1'b0;
        flush_set  = 1'b0;
        flush_clr  = 1'b0;
        case (state)
            IDLE: begin
                state_next = REQ;
                issue      = 1'b1;
            end
            REQ: begin
                // imem_req low while in REQ is the one-cycle gap after a discarded word.
                if (!imem_req) begin
                    issue = 1'b1;
                end else if (imem_ack) begin
                    req_drop  = 1'b1;
                    flush_clr = 1'b1;
                    if (!flush && !redirect) begin
                        deliver    = 1'b1;
                        pc_inc     = 1'b1;
                        state_next = HOLD;
                    end
                end else if (redirect) begin
                    flush_set = 1'b1;
                end
            end
            HOLD: begin
                if (redirect || ins_accept) begin
                    invalidate = 1'b1;
                    retire     = !redirect;
                    issue      = 1'b1;
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ins         <= '0;
            ins_valid   <= 1'b0;
            ins_pc      <= '0;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            fetch_count <= '0;
            flush       <= 1'b0;
        end else begin
            if (issue) begin
                imem_req  <= 1'b1;
                imem_addr <= issue_addr;
            end else if (req_drop) begin
                imem_req  <= 1'b0;
            end

            if (flush_clr)
                flush <= 1'b0;
            else if (flush_set)
                flush <= 1'b1;

            if (deliver) begin
                ins       <= imem_rdata;
                ins_pc    <= fetch_pc;
                ins_valid <= 1'b1;
            end else if (invalidate) begin
                ins_valid <= 1'b0;
            end

            if (retire)
                fetch_count <= fetch_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed corner sequences, a redirect/wrap table, and a
// randomized run against a program-order model of which instruction comes next.
module tb_instr_fetch_unit;

    localparam int              PC_W     = 14;
    localparam int              INS_W    = 18;
    localparam logic [PC_W-1:0] RESET_PC = '0;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [INS_W-1:0] ins;
    logic             ins_valid;
    logic [PC_W-1:0]  ins_pc;
    logic             ins_accept = 1'b0;
    logic             redirect = 1'b0;
    logic [PC_W-1:0]  redirect_pc = '0;
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_ack;
    logic [INS_W-1:0] imem_rdata;
    logic [15:0]      fetch_count;

    int n_vec = 0;
    int n_err = 0;
    int mem_wait = 0;
    bit mem_force_ack = 1'b0;

    instr_fetch_unit #(
        .PC_W     (PC_W),
        .INS_W    (INS_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ins         (ins),
        .ins_valid   (ins_valid),
        .ins_pc      (ins_pc),
        .ins_accept  (ins_accept),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [INS_W-1:0] mem_data(input logic [PC_W-1:0] a);
        if (a == '0)
            return 18'h0ABCD;
        return {a[3:0] ^ 4'h9, a ^ 14'h1555};
    endfunction

    // Memory responder: acks after mem_wait request cycles, or unconditionally when forced.
    initial begin : responder
        int cnt;
        cnt        = 0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_force_ack) begin
                imem_ack   = 1'b1;
                imem_rdata = 18'h3FFFF;
            end else if (!imem_req) begin
                imem_ack = 1'b0;
                cnt      = 0;
            end else if (cnt >= mem_wait) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_data(imem_addr);
                cnt        = 0;
            end else begin
                imem_ack = 1'b0;
                cnt++;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget);
        int i;
        i = 0;
        while (!ins_valid && i < budget) begin
            step();
            i++;
        end
        check("ins_valid_arrives", 32'(ins_valid), 32'd1);
    endtask

    typedef struct {
        logic [PC_W-1:0]  target;
        int               waits;
        logic [INS_W-1:0] exp_ins;
        logic [PC_W-1:0]  exp_next;
    } vec_t;

    vec_t tbl[5];

    initial begin : main
        int              exp_count;
        logic [PC_W-1:0] m_next;
        logic [PC_W-1:0] m_pc;
        logic [INS_W-1:0] m_ins;
        bit              m_hold;
        bit              r, a, p_req;
        logic [PC_W-1:0] p_addr;

        tbl[0] = '{14'h3FFF, 0, mem_data(14'h3FFF), 14'h0000};
        tbl[1] = '{14'h0010, 2, mem_data(14'h0010), 14'h0011};
        tbl[2] = '{14'h1FFF, 1, mem_data(14'h1FFF), 14'h2000};
        tbl[3] = '{14'h0000, 5, 18'h0ABCD,          14'h0001};
        tbl[4] = '{14'h2ABC, 0, mem_data(14'h2ABC), 14'h2ABD};

        // Reset state
        repeat (3) step();
        check("rst_ins", 32'(ins), 32'd0);
        check("rst_ins_valid", 32'(ins_valid), 32'd0);
        check("rst_ins_pc", 32'(ins_pc), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_fetch_count", 32'(fetch_count), 32'd0);

        // First fetch with a zero-wait memory
        rst = 1'b0;
        step();
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", 32'(imem_addr), 32'(RESET_PC));
        check("first_no_valid", 32'(ins_valid), 32'd0);
        step();
        check("first_valid", 32'(ins_valid), 32'd1);
        check("first_ins", 32'(ins), 32'h0ABCD);
        check("first_ins_pc", 32'(ins_pc), 32'd0);
        check("first_req_drop", 32'(imem_req), 32'd0);

        // Hold without accept for five cycles
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_valid", 32'(ins_valid), 32'd1);
            check("hold_ins", 32'(ins), 32'h0ABCD);
            check("hold_no_req", 32'(imem_req), 32'd0);
        end
        exp_count = 0;

        // Accept, then a 3-wait-state fetch redirected in its 2nd wait cycle
        mem_wait   = 3;
        ins_accept = 1'b1;
        step();
        ins_accept = 1'b0;
        exp_count++;
        check("acc_valid_low", 32'(ins_valid), 32'd0);
        check("acc_req", 32'(imem_req), 32'd1);
        check("acc_addr", 32'(imem_addr), 32'd1);
        check("acc_count", 32'(fetch_count), 32'(exp_count));
        step();
        redirect    = 1'b1;
        redirect_pc = 14'h0100;
        step();
        redirect = 1'b0;
        check("flush_addr_w3", 32'(imem_addr), 32'd1);
        check("flush_req_w3", 32'(imem_req), 32'd1);
        step();
        check("flush_addr_ack", 32'(imem_addr), 32'd1);
        check("flush_req_ack", 32'(imem_req), 32'd1);
        check("flush_no_valid", 32'(ins_valid), 32'd0);
        mem_wait = 0;
        step();
        check("flush_gap_req", 32'(imem_req), 32'd0);
        check("flush_gap_valid", 32'(ins_valid), 32'd0);
        step();
        check("reissue_req", 32'(imem_req), 32'd1);
        check("reissue_addr", 32'(imem_addr), 32'h0100);
        wait_valid(20);
        check("redir_ins_pc", 32'(ins_pc), 32'h0100);
        check("redir_ins", 32'(ins), 32'(mem_data(14'h0100)));

        // Redirect and accept in the same HOLD cycle
        redirect    = 1'b1;
        redirect_pc = 14'h0020;
        ins_accept  = 1'b1;
        step();
        redirect   = 1'b0;
        ins_accept = 1'b0;
        check("redacc_valid", 32'(ins_valid), 32'd0);
        check("redacc_count", 32'(fetch_count), 32'(exp_count));
        check("redacc_req", 32'(imem_req), 32'd1);
        check("redacc_addr", 32'(imem_addr), 32'h0020);
        wait_valid(20);
        check("redacc_ins_pc", 32'(ins_pc), 32'h0020);

        // Table: redirect in HOLD, deliver, accept, next address (incl. wrap)
        foreach (tbl[k]) begin
            mem_wait    = tbl[k].waits;
            redirect    = 1'b1;
            redirect_pc = tbl[k].target;
            step();
            redirect = 1'b0;
            check("tbl_addr", 32'(imem_addr), 32'(tbl[k].target));
            check("tbl_valid_low", 32'(ins_valid), 32'd0);
            wait_valid(30);
            check("tbl_ins_pc", 32'(ins_pc), 32'(tbl[k].target));
            check("tbl_ins", 32'(ins), 32'(tbl[k].exp_ins));
            ins_accept = 1'b1;
            step();
            ins_accept = 1'b0;
            exp_count++;
            check("tbl_next_addr", 32'(imem_addr), 32'(tbl[k].exp_next));
            check("tbl_count", 32'(fetch_count), 32'(exp_count));
            wait_valid(30);
            check("tbl_next_ins_pc", 32'(ins_pc), 32'(tbl[k].exp_next));
        end

        // Reset while a request is outstanding, with a stray ack during reset
        mem_wait   = 1000;
        ins_accept = 1'b1;
        step();
        ins_accept = 1'b0;
        check("prerst_req", 32'(imem_req), 32'd1);
        step();
        step();
        rst = 1'b1;
        #1;
        check("async_rst_req", 32'(imem_req), 32'd0);
        check("async_rst_valid", 32'(ins_valid), 32'd0);
        check("async_rst_count", 32'(fetch_count), 32'd0);
        check("async_rst_addr", 32'(imem_addr), 32'd0);
        check("async_rst_ins", 32'(ins), 32'd0);
        check("async_rst_ins_pc", 32'(ins_pc), 32'd0);
        mem_force_ack = 1'b1;
        repeat (3) step();
        check("rst_ack_valid", 32'(ins_valid), 32'd0);
        check("rst_ack_req", 32'(imem_req), 32'd0);
        mem_force_ack = 1'b0;
        mem_wait      = 0;
        rst           = 1'b0;
        step();
        check("postrst_req", 32'(imem_req), 32'd1);
        check("postrst_addr", 32'(imem_addr), 32'(RESET_PC));
        check("postrst_valid", 32'(ins_valid), 32'd0);
        wait_valid(20);
        check("postrst_ins_pc", 32'(ins_pc), 32'(RESET_PC));
        check("postrst_ins", 32'(ins), 32'h0ABCD);

        // Randomized run against the program-order model
        exp_count = 0;
        m_pc      = RESET_PC;
        m_ins     = mem_data(RESET_PC);
        m_next    = RESET_PC + 1'b1;
        m_hold    = 1'b1;
        for (int c = 0; c < 800; c++) begin
            r           = ($urandom % 8) == 0;
            a           = ($urandom % 2) == 0;
            redirect    = r;
            redirect_pc = 14'($urandom);
            ins_accept  = a;
            if (($urandom % 16) == 0)
                mem_wait = int'($urandom % 4);
            if (r) begin
                m_next = redirect_pc;
                m_hold = 1'b0;
            end else if (a && m_hold) begin
                exp_count++;
                m_hold = 1'b0;
            end
            p_req  = imem_req;
            p_addr = imem_addr;
            step();
            if (p_req && !imem_ack) begin
                check("rnd_req_stable", 32'(imem_req), 32'd1);
                check("rnd_addr_stable", 32'(imem_addr), 32'(p_addr));
            end
            if (m_hold) begin
                check("rnd_hold_valid", 32'(ins_valid), 32'd1);
                check("rnd_hold_ins", 32'(ins), 32'(m_ins));
                check("rnd_hold_pc", 32'(ins_pc), 32'(m_pc));
            end else if (ins_valid) begin
                check("rnd_deliver_pc", 32'(ins_pc), 32'(m_next));
                check("rnd_deliver_ins", 32'(ins), 32'(mem_data(m_next)));
                m_pc   = m_next;
                m_ins  = mem_data(m_next);
                m_next = m_next + 1'b1;
                m_hold = 1'b1;
            end
            check("rnd_fetch_count", 32'(fetch_count), 32'(exp_count[15:0]));
        end
        redirect   = 1'b0;
        ins_accept = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
